// File: rtl/wb_apb_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_apb_bridge_pkg
// Description : Shared types and default constants for the Wishbone-to-APB
//               bridge: FSM state encoding, default decode window, timeout
//               read-data pattern and a window-match helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package wb_apb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ACK    = 2'd3
    } bridge_state_e;

    localparam logic [31:0] DEF_WIN_LO   = 32'h3000_0000;
    localparam logic [31:0] DEF_WIN_HI   = 32'h300A_FFFF;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

    // Inclusive address-window match.
    function automatic logic in_window(input logic [31:0] adr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (adr >= lo) && (adr <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : apb_wait_timer
// Description : Loadable up-counter with a terminal-count flag. Counting
//               stops once the terminal value is reached; load wins over
//               enable.
// Ports       : clk_i      - clock
//               rst_ni     - asynchronous active-low reset
//               load_i     - load load_val_i into the counter
//               load_val_i - value loaded on load_i
//               en_i       - increment enable
//               tc_o       - counter equals TERMINAL
// Revision    : 1.0  initial release
// ============================================================================
module apb_wait_timer #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 255
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc_o = (count_q == TC_VAL);

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && !tc_o) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_apb_bridge
// Description : Converts single Wishbone classic slave cycles into APB master
//               transfers with SETUP/ACCESS phasing, wait-state handling,
//               address-window filtering and an ACCESS-phase timeout.
// Ports       : wb_clk_i / wb_rst_n          - clock, async active-low reset
//               wbs_cyc/stb/we/sel/adr/dat_i  - Wishbone request
//               wbs_ack_o / wbs_dat_o         - Wishbone response
//               m_apb_addr/sel/ena/write/wdata/pstb - APB request
//               m_apb_rdata / m_apb_rready    - APB response
//               timeout_o   - one-cycle pulse on a timed-out transfer
//               tmo_count_o - saturating count of timeouts
// Revision    : 1.0  initial release
// ============================================================================
module wb_apb_bridge
    import wb_apb_bridge_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA,
    parameter logic [31:0] WIN_LO   = DEF_WIN_LO,
    parameter logic [31:0] WIN_HI   = DEF_WIN_HI
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] m_apb_addr,
    output logic        m_apb_sel,
    output logic        m_apb_ena,
    output logic        m_apb_write,
    output logic [31:0] m_apb_wdata,
    output logic [3:0]  m_apb_pstb,
    input  logic [31:0] m_apb_rdata,
    input  logic        m_apb_rready,
    output logic        timeout_o,
    output logic [7:0]  tmo_count_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    bridge_state_e state_q, state_d;
    logic [31:0]   addr_q,  addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [3:0]    pstb_q,  pstb_d;
    logic [31:0]   rdat_q,  rdat_d;
    logic          abort_q, abort_d;
    logic          tmo_q,   tmo_d;
    logic [7:0]    tmo_cnt_q, tmo_cnt_d;

    logic          w_tc;
    logic          w_req;
    logic          w_in_win;

    assign w_req    = wbs_cyc_i && wbs_stb_i;
    assign w_in_win = in_window(wbs_adr_i, WIN_LO, WIN_HI);

    // Counter is held at zero outside ACCESS, so it is clear on every entry
    // to SETUP and after every completion.
    apb_wait_timer #(
        .WIDTH    (CNT_W),
        .TERMINAL (TIMEOUT)
    ) u_wait_timer (
        .clk_i      (wb_clk_i),
        .rst_ni     (wb_rst_n),
        .load_i     (state_q != ST_ACCESS),
        .load_val_i ('0),
        .en_i       ((state_q == ST_ACCESS) && !m_apb_rready),
        .tc_o       (w_tc)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        pstb_d    = pstb_q;
        rdat_d    = rdat_q;
        abort_d   = abort_q;
        tmo_d     = 1'b0;
        tmo_cnt_d = tmo_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    addr_d  = wbs_adr_i;
                    wdata_d = wbs_dat_i;
                    write_d = wbs_we_i;
                    pstb_d  = wbs_we_i ? wbs_sel_i : 4'b0000;
                    abort_d = 1'b0;
                    if (w_in_win) begin
                        state_d = ST_SETUP;
                    end else begin
                        rdat_d  = '0;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_SETUP: begin
                if (!wbs_cyc_i) abort_d = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                // An abandoned cycle cannot cancel the APB transfer; it only
                // suppresses the final Wishbone acknowledge.
                if (!wbs_cyc_i) abort_d = 1'b1;
                if (m_apb_rready) begin
                    rdat_d  = write_q ? 32'h0 : m_apb_rdata;
                    state_d = ST_ACK;
                end else if (w_tc) begin
                    rdat_d  = ERR_DATA;
                    tmo_d   = 1'b1;
                    if (tmo_cnt_q != 8'hFF) tmo_cnt_d = tmo_cnt_q + 8'd1;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Unconditional return: the request still visible during ACK
                // belongs to the cycle just acknowledged.
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            pstb_q    <= '0;
            rdat_q    <= '0;
            abort_q   <= 1'b0;
            tmo_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            pstb_q    <= pstb_d;
            rdat_q    <= rdat_d;
            abort_q   <= abort_d;
            tmo_q     <= tmo_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign m_apb_sel   = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign m_apb_ena   = (state_q == ST_ACCESS);
    assign m_apb_addr  = addr_q;
    assign m_apb_write = write_q;
    assign m_apb_wdata = wdata_q;
    assign m_apb_pstb  = pstb_q;
    assign wbs_ack_o   = (state_q == ST_ACK) && !abort_q;
    assign wbs_dat_o   = rdat_q;
    assign timeout_o   = tmo_q;
    assign tmo_count_o = tmo_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_apb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_apb_bridge
// Description : Self-checking bench for wb_apb_bridge. A small APB slave
//               answers after a programmable number of wait states; expected
//               latency, data and counters come from a transaction-level
//               model of the bridge's rules.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_apb_bridge;

    localparam int          TMO    = 4;
    localparam logic [31:0] W_LO   = 32'h3000_0000;
    localparam logic [31:0] W_HI   = 32'h300A_FFFF;
    localparam logic [31:0] ERRPAT = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdo;
    logic [31:0] p_addr;
    logic        p_sel, p_ena, p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_pstb;
    logic [31:0] p_rdata;
    logic        p_rready;
    logic        tmo_pulse;
    logic [7:0]  tmo_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_tmo = 0;

    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;

    wb_apb_bridge #(.TIMEOUT(TMO)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .wbs_cyc_i    (cyc),
        .wbs_stb_i    (stb),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (wdat),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (rdo),
        .m_apb_addr   (p_addr),
        .m_apb_sel    (p_sel),
        .m_apb_ena    (p_ena),
        .m_apb_write  (p_write),
        .m_apb_wdata  (p_wdata),
        .m_apb_pstb   (p_pstb),
        .m_apb_rdata  (p_rdata),
        .m_apb_rready (p_rready),
        .timeout_o    (tmo_pulse),
        .tmo_count_o  (tmo_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // APB slave: ready on the ACCESS cycle whose index equals slv_wait.
    initial begin
        int k;
        k = 0;
        p_rready = 1'b0;
        p_rdata  = '0;
        forever begin
            @(negedge clk);
            p_rdata = slv_rdata;
            if (p_sel && p_ena) begin
                p_rready = (k >= slv_wait);
                k++;
            end else begin
                p_rready = 1'b0;
                k = 0;
            end
        end
    end

    // Transaction-level model of one request.
    function automatic void model(input logic [31:0] a, input logic w,
                                  input int ws, input logic [31:0] rd,
                                  output int lat, output logic [31:0] data,
                                  output int selc, output int tmo);
        if (a < W_LO || a > W_HI) begin
            lat = 1; data = 32'h0; selc = 0; tmo = 0;
        end else if (ws <= TMO) begin
            lat = 3 + ws; data = w ? 32'h0 : rd; selc = 2 + ws; tmo = 0;
        end else begin
            lat = 3 + TMO; data = ERRPAT; selc = 2 + TMO; tmo = 1;
        end
    endfunction

    // Drive one request and observe; no checking here.
    task automatic do_txn(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] wd, input int ws, input logic [31:0] rd,
                          output int lat, output logic [31:0] rdata, output int selc,
                          output int setup_at, output int access_at,
                          output logic [31:0] addr_obs, output logic [3:0] pstb_obs,
                          output int tmo_p, output logic stable);
        logic [31:0] a0, d0;
        logic        w0;
        slv_wait  = ws;
        slv_rdata = rd;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = wd;
        lat = -1; rdata = '0; selc = 0; setup_at = -1; access_at = -1;
        addr_obs = '0; pstb_obs = '0; tmo_p = 0; stable = 1'b1;
        a0 = '0; d0 = '0; w0 = 1'b0;
        for (int c = 1; c <= TMO + 20 && lat < 0; c++) begin
            @(negedge clk);
            if (p_sel) begin
                if (selc == 0) begin
                    a0 = p_addr; d0 = p_wdata; w0 = p_write;
                    addr_obs = p_addr; pstb_obs = p_pstb;
                end else if (p_addr !== a0 || p_wdata !== d0 || p_write !== w0 ||
                             p_pstb !== pstb_obs) begin
                    stable = 1'b0;
                end
                selc++;
                if (!p_ena && setup_at < 0) setup_at = c;
                if (p_ena && access_at < 0) access_at = c;
            end
            if (tmo_pulse) tmo_p++;
            if (ack) begin
                lat = c;
                rdata = rdo;
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    // Run one request and compare every observation with the model.
    task automatic run_checked(input string nm, input logic [31:0] a, input logic w,
                               input logic [3:0] s, input int ws);
        int lat, selc, su, ac, tp, e_lat, e_selc, e_tmo;
        logic [31:0] rd, ao, e_data, wd, rdv;
        logic [3:0] po;
        logic st;
        wd  = $urandom;
        rdv = $urandom;
        do_txn(a, w, s, wd, ws, rdv, lat, rd, selc, su, ac, ao, po, tp, st);
        model(a, w, ws, rdv, e_lat, e_data, e_selc, e_tmo);
        if (e_tmo != 0) exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
        n_cmp++;
        if (lat !== e_lat) begin
            n_err++; $display("FAIL %s latency: got %0d expected %0d", nm, lat, e_lat);
        end
        n_cmp++;
        if (rd !== e_data) begin
            n_err++; $display("FAIL %s rdata: got %h expected %h", nm, rd, e_data);
        end
        n_cmp++;
        if (selc !== e_selc) begin
            n_err++; $display("FAIL %s psel cycles: got %0d expected %0d", nm, selc, e_selc);
        end
        n_cmp++;
        if (tp !== e_tmo) begin
            n_err++; $display("FAIL %s timeout pulses: got %0d expected %0d", nm, tp, e_tmo);
        end
        n_cmp++;
        if (tmo_cnt !== 8'(exp_tmo)) begin
            n_err++; $display("FAIL %s tmo_count: got %0d expected %0d", nm, tmo_cnt, exp_tmo);
        end
        if (e_selc > 0) begin
            n_cmp++;
            if (su !== 1 || ac !== 2) begin
                n_err++; $display("FAIL %s phase timing: setup %0d access %0d expected 1 2", nm, su, ac);
            end
            n_cmp++;
            if (ao !== a || po !== (w ? s : 4'b0000)) begin
                n_err++; $display("FAIL %s addr/pstb: got %h/%b expected %h/%b", nm, ao, po, a, (w ? s : 4'b0000));
            end
            n_cmp++;
            if (st !== 1'b1) begin
                n_err++; $display("FAIL %s request stability: got %b expected 1", nm, st);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0; adr = '0; wdat = '0;
        #3;
        n_cmp++;
        if ({ack, p_sel, p_ena, p_write, tmo_pulse} !== 5'b0) begin
            n_err++; $display("FAIL reset flags: got %b expected 00000", {ack, p_sel, p_ena, p_write, tmo_pulse});
        end
        n_cmp++;
        if ({rdo, p_addr, p_wdata, p_pstb, tmo_cnt} !== 108'b0) begin
            n_err++; $display("FAIL reset buses: got %h expected 0", {rdo, p_addr, p_wdata, p_pstb, tmo_cnt});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_tmo = 0;
    endtask

    task automatic test_write();
        run_checked("write", 32'h3001_0004, 1'b1, 4'b0011, 0);
    endtask

    task automatic test_read_wait();
        int lat, selc, su, ac, tp;
        logic [31:0] rd, ao;
        logic [3:0] po;
        logic st;
        do_txn(32'h3005_0000, 1'b0, 4'b1111, 32'h0, 3, 32'h1234_5678,
               lat, rd, selc, su, ac, ao, po, tp, st);
        n_cmp++;
        if (lat !== 6 || rd !== 32'h1234_5678) begin
            n_err++; $display("FAIL read_wait ack/data: got %0d/%h expected 6/12345678", lat, rd);
        end
        n_cmp++;
        if (po !== 4'b0000) begin
            n_err++; $display("FAIL read_wait pstb: got %b expected 0000", po);
        end
    endtask

    task automatic test_out_of_window();
        run_checked("oow", 32'h3010_0000, 1'b0, 4'b1111, 0);
        run_checked("oow_hi", W_HI + 32'd1, 1'b1, 4'b1111, 0);
        run_checked("oow_lo", W_LO - 32'd1, 1'b0, 4'b1111, 0);
        run_checked("edge_hi", W_HI, 1'b0, 4'b0001, 1);
        run_checked("edge_lo", W_LO, 1'b1, 4'b1000, 2);
    endtask

    task automatic test_timeout();
        run_checked("timeout", 32'h3002_0010, 1'b0, 4'b0000, 1000);
        run_checked("wait_eq_tmo", 32'h3002_0014, 1'b0, 4'b0000, TMO);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = W_LO + 32'($urandom_range(0, 32'h000A_FFFF));
                1: a = $urandom_range(0, 1) ? W_LO : W_HI;
                2: a = $urandom_range(0, 1) ? W_LO - 32'd1 : W_HI + 32'd1;
                default: a = $urandom;
            endcase
            run_checked("random", a, 1'($urandom_range(0, 1)), 4'($urandom),
                        $urandom_range(0, TMO + 2));
        end
    endtask

    task automatic test_saturation();
        int lat, selc, su, ac, tp;
        logic [31:0] rd, ao;
        logic [3:0] po;
        logic st;
        for (int i = 0; i < 300; i++) begin
            do_txn(32'h3003_0000, 1'b0, 4'b0, 32'h0, 1000, 32'h0,
                   lat, rd, selc, su, ac, ao, po, tp, st);
            exp_tmo = (exp_tmo < 255) ? exp_tmo + 1 : 255;
        end
        n_cmp++;
        if (tmo_cnt !== 8'(exp_tmo) || exp_tmo != 255) begin
            n_err++; $display("FAIL saturation tmo_count: got %0d expected 255", tmo_cnt);
        end
        n_cmp++;
        if (rd !== ERRPAT) begin
            n_err++; $display("FAIL saturation rdata: got %h expected %h", rd, ERRPAT);
        end
    endtask

    task automatic test_abort();
        int acks, acc;
        logic sel_end;
        slv_wait = 3; slv_rdata = 32'hCAFE_0001;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'b0; adr = 32'h3004_0000;
        acks = 0; acc = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (p_ena) acc++;
            if (p_ena && acc == 2) begin
                cyc = 1'b0; stb = 1'b0;
            end
            if (ack) acks++;
        end
        sel_end = p_sel;
        n_cmp++;
        if (acks !== 0) begin
            n_err++; $display("FAIL abort ack count: got %0d expected 0", acks);
        end
        n_cmp++;
        if (acc !== 4 || sel_end !== 1'b0) begin
            n_err++; $display("FAIL abort access cycles/psel: got %0d/%b expected 4/0", acc, sel_end);
        end
        run_checked("after_abort", 32'h3004_0008, 1'b0, 4'b0, 1);
    endtask

    task automatic test_reset_mid();
        int guard;
        slv_wait = 1000;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'b1111; adr = 32'h3006_0000; wdat = 32'h5555_AAAA;
        guard = 0;
        while (!p_ena && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ack, p_sel, p_ena, p_write, tmo_pulse} !== 5'b0 || guard >= 10) begin
            n_err++; $display("FAIL reset_mid flags: got %b expected 00000", {ack, p_sel, p_ena, p_write, tmo_pulse});
        end
        n_cmp++;
        if ({rdo, p_addr, p_wdata, p_pstb, tmo_cnt} !== 108'b0) begin
            n_err++; $display("FAIL reset_mid buses: got %h expected 0", {rdo, p_addr, p_wdata, p_pstb, tmo_cnt});
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_tmo = 0;
        run_checked("after_reset", 32'h3007_0000, 1'b1, 4'b0101, 2);
        run_checked("after_reset_rd", 32'h3007_0004, 1'b0, 4'b0000, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            run_checked("b2b", 32'h3008_0000 + 32'(i * 4), 1'(i % 2), 4'b1111, i);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_out_of_window();
        test_timeout();
        test_random();
        test_back_to_back();
        test_saturation();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
